ps2_receiver: RTL and testbench

- Captures 11-bit PS/2 keyboard frames (start, 8 data LSB-first, odd parity, stop) from the external ps2_clk/ps2_data lines.
- Holds the last valid scancode in a one-entry status word with valid, overrun and parity-error flags.
- Sits directly upstream of the address decoder: its status word drives the decoder's ps2_read input, and the decoder's ps2_read_ack clears it.
- The CPU polls the word with a load from 0x4000 and acknowledges it with a store to 0x4000.

---
 rtl/ps2_receiver.sv | 141 ++++++++++++++
 tb/tb_ps2_receiver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: conditions the raw ps2_clk/ps2_data lines, decodes 11-bit frames
// and keeps the last scancode with valid/overrun/parity-error flags for the CPU to poll.
module ps2_receiver #(
  parameter int N       = 32,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  input  logic         read_ack,
  output logic [N-1:0] ps2_word,
  output logic         frame_done
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_p0, clk_p1, data_p0, data_p1;
  logic          filt, filt_d, fall;
  logic [FW-1:0] filt_cnt;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tcnt;

  logic [7:0]    scancode;
  logic          valid, overrun, parity_err;

  logic          complete, good, timed_out;

  // Stage p0/p1: two-flop synchronizers, then a level filter and registered fall detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_p0   <= 1'b1;
      clk_p1   <= 1'b1;
      data_p0  <= 1'b1;
      data_p1  <= 1'b1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
      if (clk_p1 != filt) begin
        if (filt_cnt == FW'(FILTER - 1)) begin
          filt     <= clk_p1;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
      filt_d <= filt;
      fall   <= filt_d & ~filt;
    end
  end

  assign complete  = (state == STOP) && fall;
  assign good      = (^shift ^ par) & data_p1;
  assign timed_out = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));

  // Frame FSM: one step per accepted falling edge, abandoned on inactivity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (fall || timed_out) tcnt <= '0;
      else if (state != IDLE) tcnt <= tcnt + TW'(1);

      case (state)
        IDLE: if (fall && !data_p1) begin
          state   <= DATA;
          bit_cnt <= '0;
          shift   <= '0;
        end
        DATA: if (fall) begin
          shift[bit_cnt] <= data_p1;
          bit_cnt        <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: if (fall) begin
          par   <= data_p1;
          state <= STOP;
        end
        STOP: if (fall) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (timed_out) state <= IDLE;
    end
  end

  // Status word: completion wins over acknowledge, but an ack in the same cycle still clears stale flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scancode   <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= complete;
      if (complete && good) begin
        scancode <= shift;
        overrun  <= valid & ~read_ack;
        valid    <= 1'b1;
        if (read_ack) parity_err <= 1'b0;
      end else if (complete) begin
        parity_err <= 1'b1;
        if (read_ack) begin
          valid   <= 1'b0;
          overrun <= 1'b0;
        end
      end else if (read_ack) begin
        valid      <= 1'b0;
        overrun    <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end

  assign ps2_word = {{(N - 11){1'b0}}, parity_err, overrun, valid, scancode};

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: a table of frames with expected status words,
// plus hand-written sequences for timeout, glitches, reset mid-frame and ack/completion overlap.
module tb_ps2_receiver;
  localparam int TO = 200;
  localparam int H  = 20;

  logic        clk = 1'b0;
  logic        reset, ps2_clk, ps2_data, read_ack;
  logic [31:0] ps2_word;
  logic        frame_done;

  int          nvec = 0;
  int          nerr = 0;
  int          done_cnt = 0;
  int          d0;
  logic [31:0] done_word = '0;
  logic [10:0] bits;

  typedef struct {
    logic [7:0]  code;
    logic        par;
    logic        stop;
    logic        ack;
    logic [31:0] exp_frame;
    logic [31:0] exp_ack;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  ps2_receiver #(.N(32), .FILTER(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .read_ack(read_ack), .ps2_word(ps2_word), .frame_done(frame_done)
  );

  always @(posedge clk) if (frame_done) begin
    done_cnt  <= done_cnt + 1;
    done_word <= ps2_word;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk) ps2_data = b;
    repeat (H / 2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      @(negedge clk) ps2_clk = 1'b1;
    end
    repeat (H / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic p, input logic s,
                            input int nbits, input bit glitch);
    logic [10:0] fb;
    fb = {s, p, code, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fb[i], glitch);
    repeat (H) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge clk) read_ack = 1'b1;
    @(negedge clk) read_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 32'h0000011C, 32'h0000001C};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 1'b0, 32'h0000015A, 32'h0};
    vecs[2] = '{8'h29, 1'b0, 1'b1, 1'b0, 32'h00000329, 32'h0};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 1'b1, 32'h000003F0, 32'h000000F0};
    vecs[4] = '{8'h29, 1'b1, 1'b1, 1'b0, 32'h000004F0, 32'h0};
    vecs[5] = '{8'h1C, 1'b0, 1'b1, 1'b1, 32'h0000051C, 32'h0000001C};
    vecs[6] = '{8'h1C, 1'b0, 1'b0, 1'b1, 32'h0000041C, 32'h0000001C};

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; read_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_word", ps2_word, 32'h0);
    chk("reset_frame_done", {31'b0, frame_done}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      send_frame(vecs[i].code, vecs[i].par, vecs[i].stop, 11, 1'b0);
      chk($sformatf("vec%0d_word", i), ps2_word, vecs[i].exp_frame);
      chk($sformatf("vec%0d_done_pulses", i), done_cnt - d0, 32'd1);
      if (vecs[i].ack) begin
        ack_pulse();
        chk($sformatf("vec%0d_ack_word", i), ps2_word, vecs[i].exp_ack);
      end
    end

    // Partial frame abandoned by timeout, then a clean frame
    d0 = done_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, 5, 1'b0);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_no_done", done_cnt - d0, 32'd0);
    chk("timeout_word_kept", ps2_word, 32'h0000001C);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0);
    chk("after_timeout_word", ps2_word, 32'h0000015A);
    chk("after_timeout_done", done_cnt - d0, 32'd1);

    // One-cycle ps2_clk glitches during every bit must be ignored
    ack_pulse();
    chk("pre_glitch_ack", ps2_word, 32'h0000005A);
    d0 = done_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    chk("glitch_word", ps2_word, 32'h0000011C);
    chk("glitch_done", done_cnt - d0, 32'd1);

    // read_ack lands exactly in the completion cycle (2 + FILTER + 2 after the raw fall)
    bits = {1'b1, 1'b0, 8'h29, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], 1'b0);
    @(negedge clk) ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (7) @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk) read_ack = 1'b0;
    chk("coinc_latency_done", {31'b0, frame_done}, 32'h1);
    chk("coinc_word", ps2_word, 32'h00000129);
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (H) @(negedge clk);
    chk("coinc_done_word", done_word, 32'h00000129);
    read_ack = 1'b1;
    repeat (3) @(negedge clk);
    read_ack = 1'b0;
    chk("held_ack_word", ps2_word, 32'h00000029);

    // Asynchronous reset mid-frame
    send_frame(8'h1C, 1'b0, 1'b1, 4, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midframe_reset_word", ps2_word, 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("post_reset_word", ps2_word, 32'h0000011C);
    chk("post_reset_done", done_cnt - d0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
